// File: rtl/debug_sender_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_sender_pkg
//  Description : Shared debug definitions: sender FSM state encodings, word
//                size in bytes, frame item-count helper and the mode/halt
//                command codes recognised by the debug controller.
//  Revision    : 1.0  initial release
// ============================================================================
package debug_sender_pkg;

    // Sender FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } dbg_state_t;

    // Every frame word is serialised as this many bytes, LSB first
    localparam int WORD_BYTES = 4;

    // Debug-controller command codes (mode switch / halt)
    localparam logic [31:0] C_MODE_CODE = 32'hFFFF_FFFF;
    localparam logic [31:0] C_HALT_CODE = 32'h1000_1000;

    // Frame = pc + cycle_count + register file + data memory
    function automatic int frame_items(input int nregs, input int dm_depth);
        return 2 + nregs + dm_depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_sender.sv
`default_nettype none
// ============================================================================
//  Module      : debug_sender
//  Description : Dumps processor state over a byte-wide UART interface.
//                On a send_flag rising edge it sends pc_value, cycle_count,
//                every register-file word and every data-memory word, each
//                as 4 bytes LSB first, one byte per tx_start/tx_done
//                handshake, then pulses send_done.
//  Ports       : clk, reset (sync, active-low)
//                send_flag      - dump request level
//                pc_value, cycle_count, reg_data, dm_data - word sources
//                tx_done        - byte-finished pulse from the UART
//                reg_addr, dm_addr - debug read addresses
//                tx_data, tx_start - byte and start strobe to the UART
//                send_done, busy   - frame status
//  Revision    : 1.0  initial release
// ============================================================================
module debug_sender
    import debug_sender_pkg::*;
#(
    parameter int NBITS           = 32,
    parameter int NREGS           = 32,
    parameter int REG_ADDR_LENGTH = 5,
    parameter int DM_DEPTH        = 32,
    parameter int DM_ADDR_LENGTH  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send_flag,
    input  logic [NBITS-1:0]           pc_value,
    input  logic [NBITS-1:0]           cycle_count,
    input  logic [NBITS-1:0]           reg_data,
    input  logic [NBITS-1:0]           dm_data,
    input  logic                       tx_done,
    output logic [REG_ADDR_LENGTH-1:0] reg_addr,
    output logic [DM_ADDR_LENGTH-1:0]  dm_addr,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    output logic                       send_done,
    output logic                       busy
);

    localparam int C_ITEMS     = frame_items(NREGS, DM_DEPTH);
    localparam int C_ITEM_W    = (C_ITEMS > 1) ? $clog2(C_ITEMS) : 1;
    localparam int C_REG_FIRST = 2;
    localparam int C_DM_FIRST  = 2 + NREGS;

    localparam logic [C_ITEM_W-1:0] C_LAST_ITEM = C_ITEM_W'(C_ITEMS - 1);
    localparam logic [1:0]          C_LAST_BYTE = 2'(WORD_BYTES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dbg_state_t            r_state;
    dbg_state_t            w_state_next;
    logic                  r_flag_prev;
    logic [C_ITEM_W-1:0]   r_item;
    logic [C_ITEM_W-1:0]   w_item_next;
    logic [1:0]            r_byte;
    logic [1:0]            w_byte_next;
    logic [31:0]           r_shift;
    logic [31:0]           w_shift_next;

    logic                  w_start;
    logic [31:0]           w_item32;
    logic                  w_in_reg;
    logic                  w_in_dm;
    logic [31:0]           w_word;

    // Only a 0->1 transition of send_flag seen while idle begins a frame
    assign w_start  = send_flag & ~r_flag_prev & (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Address generation straight from the item counter register, so the
    // read addresses are already settled when LOAD samples the data.
    // ------------------------------------------------------------------
    assign w_item32 = 32'(r_item);
    assign w_in_reg = (w_item32 >= 32'(C_REG_FIRST)) && (w_item32 < 32'(C_DM_FIRST));
    assign w_in_dm  = (w_item32 >= 32'(C_DM_FIRST));

    assign reg_addr = w_in_reg ? REG_ADDR_LENGTH'(w_item32 - 32'(C_REG_FIRST))
                               : '0;
    assign dm_addr  = w_in_dm  ? DM_ADDR_LENGTH'(w_item32 - 32'(C_DM_FIRST))
                               : '0;

    // Word source selected by the current item
    always_comb begin
        w_word = 32'(dm_data);
        if (r_item == C_ITEM_W'(0)) begin
            w_word = 32'(pc_value);
        end else if (r_item == C_ITEM_W'(1)) begin
            w_word = 32'(cycle_count);
        end else if (w_in_reg) begin
            w_word = 32'(reg_data);
        end
    end

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_flag_prev <= 1'b0;
            r_item      <= '0;
            r_byte      <= '0;
            r_shift     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flag_prev <= send_flag;
            r_item      <= w_item_next;
            r_byte      <= w_byte_next;
            r_shift     <= w_shift_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update logic. tx_done is only consulted in
    // WAIT, so pulses arriving in any other state (including the SEND
    // cycle itself) have no effect.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_item_next  = r_item;
        w_byte_next  = r_byte;
        w_shift_next = r_shift;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_LOAD;
                    w_item_next  = '0;
                    w_byte_next  = '0;
                end
            end

            ST_LOAD: begin
                w_shift_next = w_word;
                w_state_next = ST_SEND;
            end

            ST_SEND: begin
                w_state_next = ST_WAIT;
            end

            ST_WAIT: begin
                if (tx_done) begin
                    if (r_byte != C_LAST_BYTE) begin
                        w_byte_next  = r_byte + 2'd1;
                        w_shift_next = {8'h00, r_shift[31:8]};
                        w_state_next = ST_SEND;
                    end else if (r_item != C_LAST_ITEM) begin
                        w_byte_next  = '0;
                        w_item_next  = r_item + C_ITEM_W'(1);
                        w_state_next = ST_LOAD;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_start  = (r_state == ST_SEND);
    assign send_done = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign tx_data   = r_shift[7:0];

endmodule
`default_nettype wire

// File: tb/tb_debug_sender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_sender
//  Description : Directed self-checking bench for debug_sender with a UART
//                responder model, register/memory models and a byte capture.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debug_sender;

    localparam int NREGS       = 32;
    localparam int DM_DEPTH    = 32;
    localparam int FRAME_BYTES = (2 + NREGS + DM_DEPTH) * 4;   // 264

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        send_flag = 1'b0;
    logic        tx_done   = 1'b0;
    logic [31:0] pc_value    = 32'h0000_0010;
    logic [31:0] cycle_count = 32'h0000_0005;
    logic [31:0] reg_data;
    logic [31:0] dm_data;
    logic [4:0]  reg_addr;
    logic [4:0]  dm_addr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        send_done;
    logic        busy;

    debug_sender #(
        .NBITS           (32),
        .NREGS           (NREGS),
        .REG_ADDR_LENGTH (5),
        .DM_DEPTH        (DM_DEPTH),
        .DM_ADDR_LENGTH  (5)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .send_flag   (send_flag),
        .pc_value    (pc_value),
        .cycle_count (cycle_count),
        .reg_data    (reg_data),
        .dm_data     (dm_data),
        .tx_done     (tx_done),
        .reg_addr    (reg_addr),
        .dm_addr     (dm_addr),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .send_done   (send_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Register file and data memory models
    assign reg_data = 32'(reg_addr) * 32'h0101_0101;
    assign dm_data  = 32'hC0DE_0000 + 32'(dm_addr);

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Capture / UART responder (all at the falling edge)
    // ------------------------------------------------------------------
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  bytes_q[$];
    int          frame_base     = 0;
    int          done_cnt       = 0;
    int          done_hi        = 0;
    int          addr_err       = 0;
    int          cd             = 0;
    int          rel            = 0;
    int          wrd            = 0;
    int unsigned first_cyc      = 0;
    int unsigned last_start_cyc = 0;
    int unsigned done_cyc       = 0;
    bit          inject         = 1'b0;
    bit          fast_last      = 1'b0;
    logic        prev_done      = 1'b0;
    logic [4:0]  prev_reg_addr  = '0;
    logic [4:0]  prev_dm_addr   = '0;

    always @(negedge clk) begin
        if (tx_start) begin
            rel = bytes_q.size() - frame_base;
            if (rel == 0) first_cyc = cyc;
            // First byte of a word: previous cycle was LOAD, check its address
            if (rel % 4 == 0) begin
                wrd = rel / 4;
                if (wrd >= 2 && wrd < 2 + NREGS && prev_reg_addr != 5'(wrd - 2))
                    addr_err++;
                if (wrd >= 2 + NREGS && prev_dm_addr != 5'(wrd - 2 - NREGS))
                    addr_err++;
            end
            bytes_q.push_back(tx_data);
            last_start_cyc = cyc;
        end
        if (send_done) begin
            done_hi++;
            done_cyc = cyc;
            if (!prev_done) done_cnt++;
        end
        prev_done = send_done;

        tx_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) tx_done = 1'b1;
        end else if (inject && busy) begin
            tx_done = 1'b1;              // spurious pulse in SEND/LOAD/DONE
        end
        if (tx_start) cd = (fast_last && rel == FRAME_BYTES - 1) ? 1 : 3;

        prev_reg_addr = reg_addr;
        prev_dm_addr  = dm_addr;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        int          w;
        logic [31:0] word;
        w = idx / 4;
        if (w == 0)              word = 32'h0000_0010;
        else if (w == 1)         word = 32'h0000_0005;
        else if (w < 2 + NREGS)  word = 32'(w - 2) * 32'h0101_0101;
        else                     word = 32'hC0DE_0000 + 32'(w - 2 - NREGS);
        return word[8*(idx % 4) +: 8];
    endfunction

    task automatic verify_frame(input int base, input string tag);
        int errs = 0;
        for (int k = 0; k < FRAME_BYTES; k++) begin
            if (base + k >= bytes_q.size() || bytes_q[base + k] !== exp_byte(k))
                errs++;
        end
        chk({tag, "_bytes_bad"}, 32'(errs), 32'd0);
        chk({tag, "_byte_count"}, 32'(bytes_q.size() - base), 32'(FRAME_BYTES));
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 4000) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt), 32'(target));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [7:0]  first8 [8];
    int          d0;
    int          a0;
    int          h0;
    int          n;
    int unsigned t0;

    initial begin
        first8 = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};

        // Reset state
        reset = 1'b0;
        repeat (4) tick();
        chk("rst_tx_start",  32'(tx_start),  32'd0);
        chk("rst_send_done", 32'(send_done), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_tx_data",   32'(tx_data),   32'd0);
        chk("rst_reg_addr",  32'(reg_addr),  32'd0);
        chk("rst_dm_addr",   32'(dm_addr),   32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Frame A: nominal, send_flag held through the frame and 5 cycles more
        frame_base = bytes_q.size();
        d0 = done_cnt; a0 = addr_err; h0 = done_hi;
        send_flag = 1'b1;
        t0 = cyc;
        tick();
        chk("A_busy_load", 32'(busy), 32'd1);
        wait_done(d0 + 1, "A");
        tick();
        chk("A_busy_after", 32'(busy), 32'd0);
        repeat (4) tick();
        chk("A_single_frame", 32'(done_cnt), 32'(d0 + 1));
        for (int i = 0; i < 8; i++)
            chk($sformatf("A_first_byte%0d", i), 32'(bytes_q[frame_base + i]), 32'(first8[i]));
        chk("A_reg7_byte",    32'(bytes_q[frame_base + 36]),  32'h07);
        chk("A_dm0_byte2",    32'(bytes_q[frame_base + 138]), 32'hDE);
        verify_frame(frame_base, "A");
        chk("A_latency",      32'(first_cyc - t0),            32'd2);
        chk("A_last_to_done", 32'(done_cyc - last_start_cyc), 32'd4);
        chk("A_done_width",   32'(done_hi - h0),              32'd1);
        chk("A_addr_seq",     32'(addr_err - a0),             32'd0);
        send_flag = 1'b0;
        repeat (3) tick();

        // Frame B: spurious tx_done, send_flag drop and re-rise mid-frame
        frame_base = bytes_q.size();
        d0 = done_cnt; a0 = addr_err;
        inject = 1'b1;
        send_flag = 1'b1;
        repeat (50) tick();
        send_flag = 1'b0;
        repeat (50) tick();
        send_flag = 1'b1;
        wait_done(d0 + 1, "B");
        repeat (5) tick();
        chk("B_single_frame", 32'(done_cnt), 32'(d0 + 1));
        verify_frame(frame_base, "B");
        chk("B_addr_seq", 32'(addr_err - a0), 32'd0);
        inject = 1'b0;
        send_flag = 1'b0;
        repeat (3) tick();

        // Frame C: tx_done on WAIT entry of the last byte
        frame_base = bytes_q.size();
        d0 = done_cnt; h0 = done_hi;
        fast_last = 1'b1;
        send_flag = 1'b1;
        wait_done(d0 + 1, "C");
        chk("C_last_to_done", 32'(done_cyc - last_start_cyc), 32'd2);
        tick();
        chk("C_busy_after", 32'(busy), 32'd0);
        chk("C_done_width", 32'(done_hi - h0), 32'd1);
        verify_frame(frame_base, "C");
        fast_last = 1'b0;
        send_flag = 1'b0;
        repeat (3) tick();

        // Frame D: reset after the 100th byte with send_flag held high
        frame_base = bytes_q.size();
        d0 = done_cnt;
        send_flag = 1'b1;
        n = 0;
        while (bytes_q.size() - frame_base < 100 && n < 3000) begin
            tick();
            n++;
        end
        chk("D_reach_100", 32'(bytes_q.size() - frame_base), 32'd100);
        chk("D_tx_data_b99", 32'(tx_data), 32'h16);
        reset = 1'b0;
        tick();
        chk("D_rst_tx_start",  32'(tx_start),  32'd0);
        chk("D_rst_busy",      32'(busy),      32'd0);
        chk("D_rst_send_done", 32'(send_done), 32'd0);
        chk("D_rst_tx_data",   32'(tx_data),   32'd0);
        chk("D_rst_reg_addr",  32'(reg_addr),  32'd0);
        chk("D_no_done_abort", 32'(done_cnt),  32'(d0));
        reset = 1'b1;
        frame_base = bytes_q.size();
        a0 = addr_err;
        wait_done(d0 + 1, "D");
        verify_frame(frame_base, "D");
        chk("D_addr_seq", 32'(addr_err - a0), 32'd0);
        send_flag = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_sender.md
DEBUG_SENDER -- requirements
Module: debug_sender

Interface
REQ-001 Parameter NBITS, default 32: width of every data word sent.
REQ-002 Parameter NREGS, default 32: number of register-file words sent.
REQ-003 Parameter REG_ADDR_LENGTH, default 5: register-file read address width.
REQ-004 Parameter DM_DEPTH, default 32: number of data-memory words sent.
REQ-005 Parameter DM_ADDR_LENGTH, default 5: data-memory read address width.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
REQ-008 send_flag  in  1  level from the debug controller requesting one state dump.
REQ-009 pc_value  in  NBITS  current program counter, stable while the processor is stalled.
REQ-010 cycle_count  in  NBITS  executed-cycle counter.
REQ-011 reg_data  in  NBITS  register-file debug read data, combinational from reg_addr.
REQ-012 dm_data  in  NBITS  data-memory debug read data, combinational from dm_addr.
REQ-013 tx_done  in  1  one-cycle pulse from the UART transmitter when a byte has finished.
REQ-014 reg_addr  out  REG_ADDR_LENGTH  register-file debug read address.
REQ-015 dm_addr  out  DM_ADDR_LENGTH  data-memory debug read address.
REQ-016 tx_data  out  8  byte presented to the UART transmitter.
REQ-017 tx_start  out  1  one-cycle strobe that starts the transmission of tx_data.
REQ-018 send_done  out  1  one-cycle pulse marking the end of the frame.
REQ-019 busy  out  1  high from start detection until send_done, inclusive.

Function
REQ-020 Frame order: pc_value, cycle_count, registers 0..NREGS-1, data-memory words 0..DM_DEPTH-1. The frame is 2+NREGS+DM_DEPTH words (66 words by default).
REQ-021 Each word is sent as 4 bytes, least-significant byte first. The default frame is 264 bytes.
REQ-022 A frame starts on a send_flag rising edge (send_flag=1 and its registered previous value=0) while in IDLE; a level held high across frames does not retrigger.
REQ-023 States: IDLE, LOAD, SEND, WAIT, DONE.
REQ-024 IDLE -> LOAD on start; item counter and byte counter are cleared.
REQ-025 LOAD (1 cycle): the word selected by the item counter is latched into a 32-bit shift register; reg_addr and dm_addr are driven from the item counter registers, so addresses are stable throughout LOAD.
REQ-026 LOAD -> SEND; in SEND, tx_start=1 for exactly one cycle with tx_data=shift[7:0]; SEND -> WAIT.
REQ-027 WAIT holds until tx_done=1. Then:
  - if byte counter<3: increment the byte counter, shift right by 8, go to SEND;
  - if byte counter=3 and the item is not the last: clear the byte counter, increment the item counter, go to LOAD;
  - otherwise go to DONE.
REQ-028 DONE (1 cycle): send_done=1, then go to IDLE.
REQ-029 reg_addr = item-2 while the item lies in the register range, otherwise 0; dm_addr = item-2-NREGS while the item lies in the memory range, otherwise 0. Subtraction is modulo address width.
REQ-030 tx_done outside WAIT is ignored; tx_done coinciding with the tx_start cycle is ignored.
REQ-031 send_flag falling mid-frame is ignored; the frame always completes.
REQ-032 A new send_flag rising edge during a frame is ignored; no queueing.
REQ-033 Latency: first tx_start occurs 2 cycles after the start-edge cycle. Each subsequent word adds 1 LOAD cycle.

Reset
REQ-034 While reset=0 on a clk edge: state=IDLE, all counters and the shift register are 0; tx_start, send_done and busy are 0; tx_data, reg_addr and dm_addr are 0; the send_flag history register is 0.
REQ-035 Reset mid-frame aborts the frame with no send_done. After release, a send_flag still held high counts as a rising edge, because the history register is 0.

Structure
REQ-036 A shared debug definitions package/include holds:
  - the state encodings;
  - WORD_BYTES=4;
  - the frame item-count expression;
  - the mode/halt codes 32'hFFFFFFFF and 32'h10001000, used by the debug controller.
REQ-037 The block is flat with no sub-modules; the UART transmitter is instantiated externally at the top level.

Verification
REQ-038 Default parameters: pc=32'h00000010, cycle_count=32'h00000005, send_flag rise, tx_done pulsed 3 cycles after each tx_start -> first bytes 10,00,00,00,05,00,00,00, exactly 264 tx_start pulses, then one send_done.
REQ-039 Register model reg[i]=i*32'h01010101 -> the bytes of word 2+i are all equal to i; reg_addr steps 0..31 monotonically during LOAD cycles.
REQ-040 send_flag held high for the whole frame plus 5 cycles after send_done -> exactly one frame, busy=0 after DONE.
REQ-041 Extra tx_done pulses injected in SEND and LOAD cycles -> byte stream and count unchanged (264).
REQ-042 reset=0 asserted after the 100th byte, with send_flag held high -> outputs 0 the next cycle and no send_done; after release a full 264-byte frame restarts from pc byte 0.
REQ-043 tx_done asserted in the same cycle as the WAIT entry of the last byte -> DONE next cycle, send_done high for one cycle, then IDLE.
